// File: rtl/gpio_irq_controller_if.sv
// ============================================================================
// Module      : gpio_irq_controller_if
// Description : Register bus bundle between the bus decoder and the GPIO IRQ block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpio_irq_controller_if;
    logic [15:0] data_bus_write;
    logic [15:0] data_bus_read;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        data_bus_select;

    modport master (
        output data_bus_write,
        output data_bus_addr,
        output data_bus_mode,
        output data_bus_select,
        input  data_bus_read
    );

    modport slave (
        input  data_bus_write,
        input  data_bus_addr,
        input  data_bus_mode,
        input  data_bus_select,
        output data_bus_read
    );
endinterface

`default_nettype wire

// File: rtl/gpio_irq_controller.sv
// ============================================================================
// Module      : gpio_irq_controller
// Description : 16-pin edge-detecting interrupt controller with W1C pending
//               register and a one-request-at-a-time ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_irq_controller (
    input  wire logic                  clk,
    input  wire logic                  reset,
    gpio_irq_controller_if.slave       bus,
    input  wire logic [15:0]           pin_state,
    output logic                       irq,
    output logic [3:0]                 irq_cause,
    input  wire logic                  irq_ack
);

    localparam logic [1:0]  C_S_IDLE   = 2'd0;
    localparam logic [1:0]  C_S_ASSERT = 2'd1;
    localparam logic [1:0]  C_S_GAP    = 2'd2;

    localparam logic [31:0] C_ADDR_IRQ_ENABLE = 32'h0000_4040;
    localparam logic [31:0] C_ADDR_RISE_EN    = 32'h0000_4044;
    localparam logic [31:0] C_ADDR_FALL_EN    = 32'h0000_4048;
    localparam logic [31:0] C_ADDR_PENDING    = 32'h0000_404C;
    localparam logic [31:0] C_ADDR_STATUS     = 32'h0000_4050;

    logic [15:0] irq_enable_q, irq_enable_d;
    logic [15:0] rise_en_q,    rise_en_d;
    logic [15:0] fall_en_q,    fall_en_d;
    logic [15:0] pending_q,    pending_d;
    logic [15:0] prev_state_q, prev_state_d;
    logic        primed_q,     primed_d;
    logic [1:0]  state_q,      state_d;
    logic [3:0]  cause_q,      cause_d;

    logic        w_wr_en;
    logic [15:0] w_w1c_mask;
    logic [15:0] w_rise;
    logic [15:0] w_fall;
    logic [15:0] w_ack_clear;
    logic [15:0] w_req;
    logic [3:0]  w_lowest;

    assign w_wr_en = bus.data_bus_select && (bus.data_bus_mode == 2'b10);

    // Register file, edge detection and pending update
    always_comb begin
        irq_enable_d = irq_enable_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        w_w1c_mask   = '0;
        if (w_wr_en) begin
            case (bus.data_bus_addr)
                C_ADDR_IRQ_ENABLE: irq_enable_d = bus.data_bus_write;
                C_ADDR_RISE_EN:    rise_en_d    = bus.data_bus_write;
                C_ADDR_FALL_EN:    fall_en_d    = bus.data_bus_write;
                C_ADDR_PENDING:    w_w1c_mask   = bus.data_bus_write;
                default:           ;
            endcase
        end

        // prev_state is meaningless until one sample has been taken after reset
        w_rise = primed_q ? (pin_state & ~prev_state_q) : '0;
        w_fall = primed_q ? (~pin_state & prev_state_q) : '0;

        // OR-ing new edges last lets a same-cycle edge beat any clear
        pending_d    = (pending_q & ~w_w1c_mask & ~w_ack_clear)
                     | (w_rise & rise_en_q) | (w_fall & fall_en_q);
        prev_state_d = pin_state;
        primed_d     = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable_q <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            pending_q    <= '0;
            prev_state_q <= '0;
            primed_q     <= 1'b0;
        end else begin
            irq_enable_q <= irq_enable_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            pending_q    <= pending_d;
            prev_state_q <= prev_state_d;
            primed_q     <= primed_d;
        end
    end

    assign w_req = pending_q & irq_enable_q;

    always_comb begin
        w_lowest = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_req[i]) w_lowest = 4'(i);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_S_IDLE;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // FSM: next state. GAP already guarantees the low cycle, so it may launch the next request.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            C_S_IDLE, C_S_GAP: begin
                if (|w_req) begin
                    state_d = C_S_ASSERT;
                    cause_d = w_lowest;
                end else begin
                    state_d = C_S_IDLE;
                end
            end
            C_S_ASSERT: begin
                if (irq_ack) state_d = C_S_GAP;
            end
            default: state_d = C_S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        irq         = (state_q == C_S_ASSERT);
        irq_cause   = cause_q;
        w_ack_clear = (irq && irq_ack) ? (16'd1 << cause_q) : 16'd0;
    end

    always_comb begin
        case (bus.data_bus_addr)
            C_ADDR_IRQ_ENABLE: bus.data_bus_read = irq_enable_q;
            C_ADDR_RISE_EN:    bus.data_bus_read = rise_en_q;
            C_ADDR_FALL_EN:    bus.data_bus_read = fall_en_q;
            C_ADDR_PENDING:    bus.data_bus_read = pending_q;
            C_ADDR_STATUS:     bus.data_bus_read = {irq, 11'd0, irq_cause};
            default:           bus.data_bus_read = 16'd0;
        endcase
    end

endmodule

`default_nettype wire
